glu_audio_conditioner: RTL and testbench



---
 rtl/glu_audio_pkg.sv | 24 ++
 rtl/audio_sample_fifo.sv | 65 ++++++
 rtl/glu_audio_conditioner.sv | 156 +++++++++++++++
 tb/tb_glu_audio_conditioner.sv | 434 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/glu_audio_pkg.sv
// Shared widths and helpers for the GLU audio conditioner: volume-to-gain mapping,
// 16-bit saturation and the gain-to-multiplier mapping.
package glu_audio_pkg;

   localparam int DC_ACC_W = 20;
   localparam int GAIN_W   = 8;

   // Nibble duplication maps volume 0..15 onto 0..255 in equal steps of 17.
   function automatic logic [GAIN_W-1:0] gain_target(input logic [3:0] vol, input logic mute);
      return mute ? '0 : {vol, vol};
   endfunction

   function automatic logic signed [15:0] sat16(input logic signed [DC_ACC_W-1:0] v);
      if (v > 20'sd32767)  return 16'sh7FFF;
      if (v < -20'sd32768) return 16'sh8000;
      return v[15:0];
   endfunction

   // Full-scale gain becomes an exact x1 so unity volume is bit-transparent.
   function automatic logic [GAIN_W:0] gain_mult(input logic [GAIN_W-1:0] g);
      return (g == '1) ? (GAIN_W+1)'(256) : {1'b0, g};
   endfunction

endpackage

// File: rtl/audio_sample_fifo.sv
// First-word fall-through FIFO for {L, R} sample pairs; the head output holds the
// last popped pair while empty.
module audio_sample_fifo #(
   parameter int DEPTH = 4,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk_i,
   input  logic          reset_n_i,
   input  logic          wr_en_i,
   input  logic [31:0]   wr_data_i,
   input  logic          rd_en_i,
   output logic [31:0]   rd_data_o,
   output logic          full_o,
   output logic          empty_o,
   output logic [AW:0]   count_o
);

   localparam logic [AW:0] FULL_C = (AW+1)'(DEPTH);

   logic [31:0]   mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic [31:0]   last_q, last_d;
   logic          do_push, do_pop;

   assign empty_o   = (count_q == '0);
   assign full_o    = (count_q == FULL_C);
   assign count_o   = count_q;
   assign do_pop    = rd_en_i & ~empty_o;
   assign do_push   = wr_en_i & (~full_o | do_pop);
   assign rd_data_o = empty_o ? last_q : mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      last_d   = last_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
         last_d   = mem_q[rd_ptr_q];
      end
      if (do_push && !do_pop)      count_d = count_q + 1'b1;
      else if (do_pop && !do_push) count_d = count_q - 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= wr_data_i;
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         last_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         last_q   <= last_d;
      end
   end

endmodule

// File: rtl/glu_audio_conditioner.sv
// GLU stereo conditioner: click-free volume ramp, optional DC-blocking high-pass,
// gain multiply and an output FIFO towards the audio serializer.
module glu_audio_conditioner
   import glu_audio_pkg::*;
#(
   parameter bit DC_BLOCK_ENABLE = 1'b1,
   parameter int DC_SHIFT        = 8,
   parameter int RAMP_STEP       = 1,
   parameter int FIFO_DEPTH      = 4
) (
   input  logic        clk_i,
   input  logic        reset_n_i,
   input  logic        sample_tick_i,
   input  logic [3:0]  volume_i,
   input  logic        mute_i,
   input  logic [15:0] audio_l_i,
   input  logic [15:0] audio_r_i,
   output logic [15:0] audio_l_o,
   output logic [15:0] audio_r_o,
   output logic        valid_o,
   input  logic        ready_i,
   output logic        overflow_o,
   input  logic        clear_overflow_i,
   output logic [7:0]  gain_o
);

   localparam int              AW   = $clog2(FIFO_DEPTH);
   localparam logic [GAIN_W:0] STEP = (GAIN_W+1)'(RAMP_STEP);

   logic [GAIN_W-1:0]          gain_q, gain_d, target;
   logic                       v0_q, v0_d, v1_q, v1_d, v2_q, v2_d;
   logic signed [15:0]         x_l0_q, x_l0_d, x_r0_q, x_r0_d;
   logic [GAIN_W:0]            mult0_q, mult0_d, mult1_q, mult1_d;
   logic signed [15:0]         s_l1_q, s_l1_d, s_r1_q, s_r1_d;
   logic signed [15:0]         p_l2_q, p_l2_d, p_r2_q, p_r2_d;
   logic signed [DC_ACC_W-1:0] xp_l_q, xp_l_d, yp_l_q, yp_l_d;
   logic signed [DC_ACC_W-1:0] xp_r_q, xp_r_d, yp_r_q, yp_r_d;
   logic signed [DC_ACC_W-1:0] xl_ext, xr_ext, yl, yr;
   logic signed [24:0]         prod_l, prod_r;
   logic                       ovf_q, ovf_d;
   logic [31:0]                fifo_dout;
   logic                       fifo_full, fifo_empty, fifo_pop, fifo_drop;
   logic [AW:0]                fifo_count;

   // Gain only moves on a tick; the sample captured on that tick sees the old gain.
   always_comb begin
      target = gain_target(volume_i, mute_i);
      gain_d = gain_q;
      if (sample_tick_i) begin
         if (gain_q < target) begin
            if ({1'b0, gain_q} + STEP >= {1'b0, target}) gain_d = target;
            else                                         gain_d = gain_q + STEP[GAIN_W-1:0];
         end else if (gain_q > target) begin
            if ({1'b0, gain_q} <= {1'b0, target} + STEP) gain_d = target;
            else                                         gain_d = gain_q - STEP[GAIN_W-1:0];
         end
      end
   end

   always_comb begin
      v0_d    = sample_tick_i;
      x_l0_d  = sample_tick_i ? $signed(audio_l_i) : x_l0_q;
      x_r0_d  = sample_tick_i ? $signed(audio_r_i) : x_r0_q;
      mult0_d = sample_tick_i ? gain_mult(gain_q) : mult0_q;

      xl_ext  = {{(DC_ACC_W-16){x_l0_q[15]}}, x_l0_q};
      xr_ext  = {{(DC_ACC_W-16){x_r0_q[15]}}, x_r0_q};
      yl      = xl_ext - xp_l_q + yp_l_q - (yp_l_q >>> DC_SHIFT);
      yr      = xr_ext - xp_r_q + yp_r_q - (yp_r_q >>> DC_SHIFT);
      v1_d    = v0_q;
      xp_l_d  = v0_q ? xl_ext : xp_l_q;
      yp_l_d  = v0_q ? yl     : yp_l_q;
      xp_r_d  = v0_q ? xr_ext : xp_r_q;
      yp_r_d  = v0_q ? yr     : yp_r_q;
      s_l1_d  = v0_q ? (DC_BLOCK_ENABLE ? sat16(yl) : x_l0_q) : s_l1_q;
      s_r1_d  = v0_q ? (DC_BLOCK_ENABLE ? sat16(yr) : x_r0_q) : s_r1_q;
      mult1_d = v0_q ? mult0_q : mult1_q;

      // Multiplier tops out at 256, so the floor-shifted product always fits 16 bits.
      prod_l  = s_l1_q * $signed({1'b0, mult1_q});
      prod_r  = s_r1_q * $signed({1'b0, mult1_q});
      v2_d    = v1_q;
      p_l2_d  = v1_q ? 16'(prod_l >>> 8) : p_l2_q;
      p_r2_d  = v1_q ? 16'(prod_r >>> 8) : p_r2_q;
   end

   audio_sample_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .wr_en_i   (v2_q),
      .wr_data_i ({p_l2_q, p_r2_q}),
      .rd_en_i   (ready_i),
      .rd_data_o (fifo_dout),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty),
      .count_o   (fifo_count)
   );

   assign fifo_pop  = ready_i & ~fifo_empty;
   assign fifo_drop = v2_q & fifo_full & ~fifo_pop;

   always_comb begin
      ovf_d = ovf_q;
      if (fifo_drop)             ovf_d = 1'b1;
      else if (clear_overflow_i) ovf_d = 1'b0;
   end

   assign audio_l_o  = fifo_dout[31:16];
   assign audio_r_o  = fifo_dout[15:0];
   assign valid_o    = (fifo_count != '0);
   assign overflow_o = ovf_q;
   assign gain_o     = gain_q;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         gain_q  <= '0;
         v0_q    <= 1'b0;
         v1_q    <= 1'b0;
         v2_q    <= 1'b0;
         x_l0_q  <= '0;
         x_r0_q  <= '0;
         mult0_q <= '0;
         mult1_q <= '0;
         s_l1_q  <= '0;
         s_r1_q  <= '0;
         p_l2_q  <= '0;
         p_r2_q  <= '0;
         xp_l_q  <= '0;
         yp_l_q  <= '0;
         xp_r_q  <= '0;
         yp_r_q  <= '0;
         ovf_q   <= 1'b0;
      end else begin
         gain_q  <= gain_d;
         v0_q    <= v0_d;
         v1_q    <= v1_d;
         v2_q    <= v2_d;
         x_l0_q  <= x_l0_d;
         x_r0_q  <= x_r0_d;
         mult0_q <= mult0_d;
         mult1_q <= mult1_d;
         s_l1_q  <= s_l1_d;
         s_r1_q  <= s_r1_d;
         p_l2_q  <= p_l2_d;
         p_r2_q  <= p_r2_d;
         xp_l_q  <= xp_l_d;
         yp_l_q  <= yp_l_d;
         xp_r_q  <= xp_r_d;
         yp_r_q  <= yp_r_d;
         ovf_q   <= ovf_d;
      end
   end

endmodule

// File: tb/tb_glu_audio_conditioner.sv
// Bench for glu_audio_conditioner: three configurations driven in parallel and
// compared against a queue-based behavioural model of the conditioning chain.
module tb_glu_audio_conditioner;

   localparam int DEPTH = 4;
   localparam int P_DC   [3] = '{0, 1, 0};
   localparam int P_STEP [3] = '{1, 1, 200};

   logic        clk_i = 1'b0;
   logic        reset_n_i;
   logic        tick_i, mute_i, ready_i, clr_i;
   logic [3:0]  vol_i;
   logic [15:0] l_i, r_i;
   logic [15:0] o_l [3];
   logic [15:0] o_r [3];
   logic        o_v [3];
   logic        o_ovf [3];
   logic [7:0]  o_g [3];

   int errors = 0;
   int checks = 0;

   always #5 clk_i = ~clk_i;

   glu_audio_conditioner #(.DC_BLOCK_ENABLE(1'b0), .DC_SHIFT(8), .RAMP_STEP(1), .FIFO_DEPTH(DEPTH)) u_a (
      .clk_i(clk_i), .reset_n_i(reset_n_i), .sample_tick_i(tick_i), .volume_i(vol_i), .mute_i(mute_i),
      .audio_l_i(l_i), .audio_r_i(r_i), .audio_l_o(o_l[0]), .audio_r_o(o_r[0]), .valid_o(o_v[0]),
      .ready_i(ready_i), .overflow_o(o_ovf[0]), .clear_overflow_i(clr_i), .gain_o(o_g[0]));

   glu_audio_conditioner #(.DC_BLOCK_ENABLE(1'b1), .DC_SHIFT(8), .RAMP_STEP(1), .FIFO_DEPTH(DEPTH)) u_b (
      .clk_i(clk_i), .reset_n_i(reset_n_i), .sample_tick_i(tick_i), .volume_i(vol_i), .mute_i(mute_i),
      .audio_l_i(l_i), .audio_r_i(r_i), .audio_l_o(o_l[1]), .audio_r_o(o_r[1]), .valid_o(o_v[1]),
      .ready_i(ready_i), .overflow_o(o_ovf[1]), .clear_overflow_i(clr_i), .gain_o(o_g[1]));

   glu_audio_conditioner #(.DC_BLOCK_ENABLE(1'b0), .DC_SHIFT(8), .RAMP_STEP(200), .FIFO_DEPTH(DEPTH)) u_c (
      .clk_i(clk_i), .reset_n_i(reset_n_i), .sample_tick_i(tick_i), .volume_i(vol_i), .mute_i(mute_i),
      .audio_l_i(l_i), .audio_r_i(r_i), .audio_l_o(o_l[2]), .audio_r_o(o_r[2]), .valid_o(o_v[2]),
      .ready_i(ready_i), .overflow_o(o_ovf[2]), .clear_overflow_i(clr_i), .gain_o(o_g[2]));

   // ---------------- behavioural model ----------------
   int          m_gain [3];
   int          m_xp [3][2];
   int          m_yp [3][2];
   bit          m_ovf [3];
   logic [31:0] m_last [3];
   logic [31:0] m_fifo [3][$];
   logic [31:0] pend_d [3][$];
   int          pend_t [3][$];
   int          cyc = 0;

   function automatic int ramp(int g, int t, int st);
      if (g < t) return (g + st > t) ? t : g + st;
      if (g > t) return (g - st < t) ? t : g - st;
      return g;
   endfunction

   function automatic int scale(int s, int g);
      int m;
      m = (g == 255) ? 256 : g;
      return (s * m) >>> 8;
   endfunction

   function automatic int dc(int i, int ch, int x);
      int y;
      logic signed [19:0] w;
      if (P_DC[i] == 0) return x;
      y = x - m_xp[i][ch] + m_yp[i][ch] - (m_yp[i][ch] >>> 8);
      w = 20'(y);
      y = w;
      m_xp[i][ch] = x;
      m_yp[i][ch] = y;
      if (y > 32767)  return 32767;
      if (y < -32768) return -32768;
      return y;
   endfunction

   function automatic logic [31:0] m_head(int i);
      return (m_fifo[i].size() != 0) ? m_fifo[i][0] : m_last[i];
   endfunction

   task automatic model_reset();
      cyc = 0;
      for (int i = 0; i < 3; i++) begin
         m_gain[i] = 0;
         m_ovf[i]  = 1'b0;
         m_last[i] = '0;
         m_fifo[i].delete();
         pend_d[i].delete();
         pend_t[i].delete();
         for (int c = 0; c < 2; c++) begin
            m_xp[i][c] = 0;
            m_yp[i][c] = 0;
         end
      end
   endtask

   task automatic model_edge();
      logic [31:0] d;
      bit pop, push, drop, was_full;
      int sl, sr, t;
      if (!reset_n_i) return;
      cyc++;
      for (int i = 0; i < 3; i++) begin
         pop      = ready_i && (m_fifo[i].size() != 0);
         push     = (pend_t[i].size() != 0) && (pend_t[i][0] == cyc);
         was_full = (m_fifo[i].size() == DEPTH);
         drop     = push && was_full && !pop;
         if (pop) m_last[i] = m_fifo[i].pop_front();
         if (push) begin
            d = pend_d[i].pop_front();
            void'(pend_t[i].pop_front());
            if (!drop) m_fifo[i].push_back(d);
         end
         if (drop)       m_ovf[i] = 1'b1;
         else if (clr_i) m_ovf[i] = 1'b0;
         if (tick_i) begin
            sl = scale(dc(i, 0, int'($signed(l_i))), m_gain[i]);
            sr = scale(dc(i, 1, int'($signed(r_i))), m_gain[i]);
            pend_d[i].push_back({16'(sl), 16'(sr)});
            pend_t[i].push_back(cyc + 3);
            t = mute_i ? 0 : int'(vol_i) * 17;
            m_gain[i] = ramp(m_gain[i], t, P_STEP[i]);
         end
      end
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic cycle();
      @(posedge clk_i);
      model_edge();
      #1;
   endtask

   task automatic tick_once(input logic [15:0] l, input logic [15:0] r);
      tick_i = 1'b1;
      l_i = l;
      r_i = r;
      cycle();
      tick_i = 1'b0;
   endtask

   task automatic do_reset();
      reset_n_i = 1'b0;
      model_reset();
      repeat (2) @(posedge clk_i);
      #1 reset_n_i = 1'b1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset_n_i = 1'b0;
      model_reset();
      #3;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (o_v[i] !== 1'b0 || o_g[i] !== 8'd0 || o_ovf[i] !== 1'b0 || o_l[i] !== 16'd0 || o_r[i] !== 16'd0) begin
            errors++;
            $display("FAIL reset_state inst=%0d got v=%b g=%0d ovf=%b l=%h r=%h want all zero",
                     i, o_v[i], o_g[i], o_ovf[i], o_l[i], o_r[i]);
         end
      end
      repeat (2) @(posedge clk_i);
      #1 reset_n_i = 1'b1;
      repeat (2) cycle();
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (o_v[i] !== 1'b0 || o_g[i] !== 8'd0) begin
            errors++;
            $display("FAIL reset_release inst=%0d got v=%b g=%0d want v=0 g=0", i, o_v[i], o_g[i]);
         end
      end
   endtask

   task automatic test_ramp();
      vol_i = 4'd15; mute_i = 1'b0; ready_i = 1'b1;
      repeat (10) tick_once(16'($urandom), 16'($urandom));
      checks++;
      if (o_g[0] !== 8'd10) begin
         errors++; $display("FAIL ramp_up10 got=%0d want=10", o_g[0]);
      end
      checks++;
      if (o_g[2] !== 8'(m_gain[2])) begin
         errors++; $display("FAIL ramp_up_step200 got=%0d want=%0d", o_g[2], m_gain[2]);
      end
      mute_i = 1'b1;
      repeat (3) tick_once(16'($urandom), 16'($urandom));
      checks++;
      if (o_g[0] !== 8'd7) begin
         errors++; $display("FAIL ramp_mute got=%0d want=7", o_g[0]);
      end
      checks++;
      if (o_g[2] !== 8'd0) begin
         errors++; $display("FAIL ramp_mute_step200 got=%0d want=0", o_g[2]);
      end
      mute_i = 1'b0; vol_i = 4'd8;
      for (int k = 0; k < 2; k++) begin
         tick_once(16'($urandom), 16'($urandom));
         checks++;
         if (o_g[2] !== 8'd136) begin
            errors++; $display("FAIL ramp_no_overshoot tick=%0d got=%0d want=136", k, o_g[2]);
         end
         checks++;
         if (o_g[0] !== 8'(m_gain[0])) begin
            errors++; $display("FAIL ramp_step1 tick=%0d got=%0d want=%0d", k, o_g[0], m_gain[0]);
         end
      end
   endtask

   task automatic test_unity();
      vol_i = 4'd15; ready_i = 1'b1;
      for (int k = 0; k < 300 && m_gain[0] != 255; k++) tick_once(16'($urandom), 16'($urandom));
      checks++;
      if (o_g[0] !== 8'd255) begin
         errors++; $display("FAIL unity_gain got=%0d want=255", o_g[0]);
      end
      repeat (5) cycle();
      tick_once(16'h4000, 16'hC000);
      repeat (2) cycle();
      checks++;
      if (o_v[0] !== 1'b0) begin
         errors++; $display("FAIL unity_latency_early got valid=%b want 0", o_v[0]);
      end
      cycle();
      checks++;
      if (o_v[0] !== 1'b1 || o_l[0] !== 16'h4000 || o_r[0] !== 16'hC000) begin
         errors++;
         $display("FAIL unity_passthru got v=%b l=%h r=%h want v=1 l=4000 r=c000", o_v[0], o_l[0], o_r[0]);
      end
   endtask

   task automatic test_overflow();
      logic [15:0] exp_seq [4];
      exp_seq[0] = 16'd2; exp_seq[1] = 16'd3; exp_seq[2] = 16'd4; exp_seq[3] = 16'd9;
      ready_i = 1'b1; clr_i = 1'b0;
      repeat (5) cycle();
      ready_i = 1'b0;
      for (int k = 1; k <= 5; k++) tick_once(16'(k), 16'(-k));
      repeat (3) cycle();
      checks++;
      if (o_ovf[0] !== 1'b1 || o_v[0] !== 1'b1) begin
         errors++; $display("FAIL ovf_set got ovf=%b v=%b want 1 1", o_ovf[0], o_v[0]);
      end
      ready_i = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         checks++;
         if (o_v[0] !== 1'b1 || o_l[0] !== 16'(k) || o_r[0] !== 16'(-k)) begin
            errors++;
            $display("FAIL ovf_pop_order k=%0d got v=%b l=%h r=%h want v=1 l=%h r=%h",
                     k, o_v[0], o_l[0], o_r[0], 16'(k), 16'(-k));
         end
         cycle();
      end
      checks++;
      if (o_v[0] !== 1'b0 || o_l[0] !== 16'd4 || o_ovf[0] !== 1'b1) begin
         errors++;
         $display("FAIL ovf_drained got v=%b l=%h ovf=%b want v=0 l=0004 ovf=1", o_v[0], o_l[0], o_ovf[0]);
      end
      clr_i = 1'b1; cycle(); clr_i = 1'b0;
      checks++;
      if (o_ovf[0] !== 1'b0) begin
         errors++; $display("FAIL ovf_clear got=%b want=0", o_ovf[0]);
      end
      ready_i = 1'b0;
      for (int k = 1; k <= 4; k++) tick_once(16'(k), 16'(-k));
      tick_once(16'd9, 16'(-9));
      repeat (2) cycle();
      ready_i = 1'b1; cycle(); ready_i = 1'b0;
      checks++;
      if (o_ovf[0] !== 1'b0 || o_v[0] !== 1'b1) begin
         errors++; $display("FAIL full_push_pop got ovf=%b v=%b want ovf=0 v=1", o_ovf[0], o_v[0]);
      end
      ready_i = 1'b1;
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (o_v[0] !== 1'b1 || o_l[0] !== exp_seq[k]) begin
            errors++;
            $display("FAIL full_push_pop_order k=%0d got v=%b l=%h want v=1 l=%h", k, o_v[0], o_l[0], exp_seq[k]);
         end
         cycle();
      end
      ready_i = 1'b0;
      for (int k = 11; k <= 14; k++) tick_once(16'(k), 16'(-k));
      tick_once(16'd15, 16'(-15));
      repeat (2) cycle();
      clr_i = 1'b1; cycle(); clr_i = 1'b0;
      checks++;
      if (o_ovf[0] !== 1'b1) begin
         errors++; $display("FAIL ovf_set_beats_clear got=%b want=1", o_ovf[0]);
      end
      clr_i = 1'b1; cycle(); clr_i = 1'b0;
      ready_i = 1'b1;
      repeat (6) cycle();
      checks++;
      if (o_ovf[0] !== 1'b0 || o_v[0] !== 1'b0) begin
         errors++; $display("FAIL ovf_final got ovf=%b v=%b want 0 0", o_ovf[0], o_v[0]);
      end
   endtask

   task automatic test_dc_block();
      logic [15:0] xs [5];
      logic [31:0] e;
      xs[0] = 16'h2000; xs[1] = 16'h2000; xs[2] = 16'h2000; xs[3] = 16'h7FFF; xs[4] = 16'h8000;
      do_reset();
      vol_i = 4'd15; mute_i = 1'b0; ready_i = 1'b1;
      for (int k = 0; k < 300 && m_gain[1] != 255; k++) tick_once(16'd0, 16'd0);
      repeat (5) cycle();
      for (int k = 0; k < 5; k++) begin
         tick_once(xs[k], 16'd0 - xs[k]);
         repeat (3) cycle();
         e = m_head(1);
         checks++;
         if (o_v[1] !== 1'b1 || o_l[1] !== e[31:16] || o_r[1] !== e[15:0]) begin
            errors++;
            $display("FAIL dc_model k=%0d got v=%b l=%h r=%h want v=1 l=%h r=%h",
                     k, o_v[1], o_l[1], o_r[1], e[31:16], e[15:0]);
         end
         if (k == 0 || k == 1 || k == 4) begin
            checks++;
            if (o_l[1] !== ((k == 0) ? 16'h2000 : (k == 1) ? 16'h1FE0 : 16'h8000)) begin
               errors++;
               $display("FAIL dc_const k=%0d got l=%h want %h", k, o_l[1],
                        (k == 0) ? 16'h2000 : (k == 1) ? 16'h1FE0 : 16'h8000);
            end
         end
         if (k == 2) begin
            checks++;
            if (!(o_l[1] < 16'h1FE0 && o_l[1] > 16'h1000)) begin
               errors++; $display("FAIL dc_decay got l=%h want below 1fe0", o_l[1]);
            end
         end
      end
   endtask

   task automatic test_volume8();
      vol_i = 4'd8; ready_i = 1'b1;
      for (int k = 0; k < 200 && m_gain[0] != 136; k++) tick_once(16'($urandom), 16'($urandom));
      checks++;
      if (o_g[0] !== 8'd136) begin
         errors++; $display("FAIL vol8_gain got=%0d want=136", o_g[0]);
      end
      repeat (5) cycle();
      tick_once(16'h1000, 16'hF000);
      repeat (3) cycle();
      for (int i = 0; i < 3; i += 2) begin
         checks++;
         if (o_v[i] !== 1'b1 || o_l[i] !== 16'h0880 || o_r[i] !== 16'hF780) begin
            errors++;
            $display("FAIL vol8_scale inst=%0d got v=%b l=%h r=%h want v=1 l=0880 r=f780",
                     i, o_v[i], o_l[i], o_r[i]);
         end
      end
   endtask

   task automatic test_random();
      logic [31:0] e;
      for (int n = 0; n < 400; n++) begin
         tick_i  = ($urandom_range(0, 1) == 1);
         vol_i   = 4'($urandom);
         mute_i  = ($urandom_range(0, 7) == 0);
         l_i     = 16'($urandom);
         r_i     = 16'($urandom);
         ready_i = ($urandom_range(0, 3) != 0);
         clr_i   = ($urandom_range(0, 15) == 0);
         cycle();
         for (int i = 0; i < 3; i++) begin
            e = m_head(i);
            checks++;
            if (o_v[i] !== (m_fifo[i].size() != 0) || o_l[i] !== e[31:16] || o_r[i] !== e[15:0]) begin
               errors++;
               $display("FAIL rand_data n=%0d inst=%0d got v=%b l=%h r=%h want v=%b l=%h r=%h",
                        n, i, o_v[i], o_l[i], o_r[i], (m_fifo[i].size() != 0), e[31:16], e[15:0]);
            end
            checks++;
            if (o_g[i] !== 8'(m_gain[i]) || o_ovf[i] !== m_ovf[i]) begin
               errors++;
               $display("FAIL rand_state n=%0d inst=%0d got g=%0d ovf=%b want g=%0d ovf=%b",
                        n, i, o_g[i], o_ovf[i], m_gain[i], m_ovf[i]);
            end
         end
      end
      tick_i = 1'b0; clr_i = 1'b0; mute_i = 1'b0;
   endtask

   task automatic test_reset_midstream();
      ready_i = 1'b1; clr_i = 1'b0; vol_i = 4'd15;
      repeat (6) cycle();
      ready_i = 1'b0;
      for (int k = 0; k < 3; k++) tick_once(16'($urandom), 16'($urandom));
      repeat (3) cycle();
      checks++;
      if (o_v[0] !== 1'b1 || m_fifo[0].size() != 3) begin
         errors++; $display("FAIL mid_fill got v=%b depth=%0d want v=1 depth=3", o_v[0], m_fifo[0].size());
      end
      tick_once(16'h1234, 16'h4321);
      #2 reset_n_i = 1'b0;
      model_reset();
      #1;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (o_v[i] !== 1'b0 || o_g[i] !== 8'd0 || o_ovf[i] !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset inst=%0d got v=%b g=%0d ovf=%b want 0 0 0", i, o_v[i], o_g[i], o_ovf[i]);
         end
      end
      repeat (2) @(posedge clk_i);
      #1 reset_n_i = 1'b1;
      ready_i = 1'b1;
      for (int k = 0; k < 6; k++) begin
         cycle();
         checks++;
         if (o_v[0] !== 1'b0 || o_v[1] !== 1'b0 || o_v[2] !== 1'b0) begin
            errors++;
            $display("FAIL mid_stale k=%0d got v=%b%b%b want 000", k, o_v[0], o_v[1], o_v[2]);
         end
      end
   endtask

   initial begin
      reset_n_i = 1'b0;
      tick_i = 1'b0; mute_i = 1'b0; ready_i = 1'b0; clr_i = 1'b0;
      vol_i = 4'd0; l_i = 16'd0; r_i = 16'd0;
      test_reset();
      test_ramp();
      test_unity();
      test_overflow();
      test_dc_block();
      test_volume8();
      test_random();
      test_reset_midstream();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
